// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button gesture decoder.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DOWN1,
        HELD,
        WAIT2,
        DOWN2
    } gesture_state_t;

    // Defaults assume a 12 MHz clock.
    localparam int unsigned DB_CYC_DEF   = 240000;   // 20 ms debounce
    localparam int unsigned LONG_CYC_DEF = 6000000;  // 500 ms long-press
    localparam int unsigned DBL_CYC_DEF  = 3000000;  // 250 ms double-press window
    localparam int unsigned REP_CYC_DEF  = 1200000;  // 100 ms auto-repeat

    // Largest of the four timing constants; sizes the shared gesture counter.
    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-count debounce. Produces the debounced
// level and one-cycle rise/fall events aligned with the level change.
module btn_debounce #(
    parameter int unsigned DB_CYC = 240000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned DW = $clog2(DB_CYC) + 1;

    logic [1:0]    sync_q;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          rise_q, fall_q;

    // Level follows the synced input only after DB_CYC consecutive disagreeing cycles.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q >= DW'(DB_CYC - 1)) begin
                lvl_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + DW'(1);
            end
        end
    end

    // Synchroniser, debounce state and edge events (edge flags coincide with the new level).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            rise_q <= lvl_d & ~lvl_q;
            fall_q <= ~lvl_d & lvl_q;
        end
    end

    assign lvl_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/btn_gesture_decoder.sv
// Button gesture decoder: debounced level plus SHORT / LONG / DOUBLE pulses.
// Optional auto-repeat while held past LONG is enabled by GESTURE_REPEAT_EN.
module btn_gesture_decoder
    import btn_pkg::*;
#(
    parameter int unsigned DB_CYC   = DB_CYC_DEF,
    parameter int unsigned LONG_CYC = LONG_CYC_DEF,
    parameter int unsigned DBL_CYC  = DBL_CYC_DEF,
    parameter int unsigned REP_CYC  = REP_CYC_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic LVL,
    output logic SHORT,
    output logic LONG,
    output logic DOUBLE,
    output logic REPEAT
);

    localparam int unsigned CW = $clog2(max4(DB_CYC, LONG_CYC, DBL_CYC, REP_CYC)) + 1;
    localparam logic [CW-1:0] CNT_MAX = '1;

    logic rise, fall;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db (
        .clk_i  (CLK),
        .rst_i  (RST),
        .btn_i  (BTN),
        .lvl_o  (LVL),
        .rise_o (rise),
        .fall_o (fall)
    );

    gesture_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           short_q, short_d;
    logic           long_q, long_d;
    logic           dbl_q, dbl_d;
`ifdef GESTURE_REPEAT_EN
    logic           rep_q, rep_d;
`endif

    // Next-state and pulse decode. CNT holds the cycles elapsed since the event that
    // entered the state: the edge cycle counts as 0, so edge-entered states start at 1,
    // while timeout-entered states start at 0 (the pulse cycle is the reference).
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
`ifdef GESTURE_REPEAT_EN
        rep_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = DOWN1;
                    cnt_d   = CW'(1);
                end
            end
            DOWN1: begin
                if (fall) begin
                    state_d = WAIT2;
                    cnt_d   = CW'(1);
                end else if (cnt_q >= CW'(LONG_CYC - 1)) begin
                    long_d  = 1'b1;
                    state_d = HELD;
                    cnt_d   = '0;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`ifdef GESTURE_REPEAT_EN
                else if (cnt_q >= CW'(REP_CYC - 1)) begin
                    rep_d = 1'b1;
                    cnt_d = '0;
                end
`endif
            end
            WAIT2: begin
                // A new press beats the timeout when both land together.
                if (rise) begin
                    state_d = DOWN2;
                    cnt_d   = CW'(1);
                end else if (cnt_q >= CW'(DBL_CYC - 1)) begin
                    short_d = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            DOWN2: begin
                if (fall) begin
                    dbl_d   = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // FSM, shared counter and registered pulse outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            dbl_q   <= 1'b0;
`ifdef GESTURE_REPEAT_EN
            rep_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            dbl_q   <= dbl_d;
`ifdef GESTURE_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

    assign SHORT  = short_q;
    assign LONG   = long_q;
    assign DOUBLE = dbl_q;
`ifdef GESTURE_REPEAT_EN
    assign REPEAT = rep_q;
`else
    assign REPEAT = 1'b0;
`endif

endmodule
